// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin two-master APB arbiter; optional ACCESS timeout with APB_ARB_TIMEOUT_EN
module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rts,
    input  logic [ADDR_WIDTH-1:0] m0_paddr,
    input  logic [DATA_WIDTH-1:0] m0_pdata,
    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic                  m0_pwrite,
    input  logic [3:0]            m0_pstb,
    output logic [DATA_WIDTH-1:0] m0_prdata,
    output logic                  m0_pready,
    output logic                  m0_perr,
    input  logic [ADDR_WIDTH-1:0] m1_paddr,
    input  logic [DATA_WIDTH-1:0] m1_pdata,
    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic                  m1_pwrite,
    input  logic [3:0]            m1_pstb,
    output logic [DATA_WIDTH-1:0] m1_prdata,
    output logic                  m1_pready,
    output logic                  m1_perr,
    output logic [ADDR_WIDTH-1:0] APB_paddr,
    output logic [DATA_WIDTH-1:0] APB_pdata,
    output logic                  APB_pwrite,
    output logic [3:0]            APB_pstb,
    output logic                  APB_psel,
    output logic                  APB_penable,
    input  logic [DATA_WIDTH-1:0] APB_prdata,
    input  logic                  APB_pready,
    input  logic                  APB_perr,
    output logic [1:0]            grant
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_nxt;
    logic [1:0] req, elig, pick;
    logic take, done, tmo, last, perr_q;
    logic unused_ok;
    assign unused_ok = &{1'b0, m0_penable, m1_penable, TIMEOUT[0]};
`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt;
    // count ACCESS cycles; held at zero everywhere else so each ACCESS starts fresh
    always_ff @(posedge clk) begin
        cnt <= (rts || state != ACCESS) ? '0 : cnt + 1'b1;
    end
    assign tmo = (state == ACCESS) && (cnt == CW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif
    // arbitration, next state and combinational port outputs
    always_comb begin
        req         = {m1_psel, m0_psel};
        elig        = (state == RESP) ? (req & ~grant) : req;
        pick        = (elig == 2'b11) ? (last ? 2'b01 : 2'b10) : elig;
        take        = (state == IDLE || state == RESP) && (elig != 2'b00);
        done        = (state == ACCESS) && (APB_pready || tmo);
        state_nxt   = take ? SETUP :
                      (state == SETUP) ? ACCESS :
                      done ? RESP :
                      (state == RESP) ? IDLE : state;
        APB_psel    = (state == SETUP) || (state == ACCESS);
        APB_penable = (state == ACCESS);
        m0_pready   = (state == RESP) && grant[0] && m0_psel;
        m1_pready   = (state == RESP) && grant[1] && m1_psel;
        m0_perr     = m0_pready && perr_q;
        m1_perr     = m1_pready && perr_q;
    end
    // state register, request capture on grant and response capture on completion
    always_ff @(posedge clk) begin
        if (rts) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last       <= 1'b1;
            perr_q     <= 1'b0;
            APB_paddr  <= '0;
            APB_pdata  <= '0;
            APB_pwrite <= 1'b0;
            APB_pstb   <= '0;
            m0_prdata  <= '0;
            m1_prdata  <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                grant      <= pick;
                last       <= pick[1];
                APB_paddr  <= pick[1] ? m1_paddr : m0_paddr;
                APB_pdata  <= pick[1] ? m1_pdata : m0_pdata;
                APB_pwrite <= pick[1] ? m1_pwrite : m0_pwrite;
                APB_pstb   <= pick[1] ? m1_pstb : m0_pstb;
            end else if (state == RESP) begin
                grant <= 2'b00;
            end
            if (done) begin
                perr_q <= APB_pready ? APB_perr : 1'b1;
                if (grant[0]) m0_prdata <= APB_pready ? APB_prdata : '0;
                if (grant[1]) m1_prdata <= APB_pready ? APB_prdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed checks of the two-master APB arbiter
module tb_apb_arbiter;
    logic        clk = 1'b0;
    logic        rts = 1'b1;
    logic [31:0] m0_paddr, m0_pdata, m1_paddr, m1_pdata;
    logic        m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite;
    logic [3:0]  m0_pstb, m1_pstb;
    logic [31:0] m0_prdata, m1_prdata, APB_paddr, APB_pdata;
    logic        m0_pready, m0_perr, m1_pready, m1_perr;
    logic        APB_pwrite, APB_psel, APB_penable;
    logic [3:0]  APB_pstb;
    logic [1:0]  grant;
    wire  [31:0] APB_prdata;
    wire         APB_pready, APB_perr;
    int          waits = 0;
    int          wcnt = 0;
    int          cyc_no = 0;
    logic        slave_err = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;
    typedef struct { logic [1:0] g; logic [31:0] a; logic [31:0] d; int t; } xfer_t;
    xfer_t       log_q[$];

    apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rts(rts),
        .m0_paddr(m0_paddr), .m0_pdata(m0_pdata), .m0_psel(m0_psel), .m0_penable(m0_penable),
        .m0_pwrite(m0_pwrite), .m0_pstb(m0_pstb), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
        .m0_perr(m0_perr),
        .m1_paddr(m1_paddr), .m1_pdata(m1_pdata), .m1_psel(m1_psel), .m1_penable(m1_penable),
        .m1_pwrite(m1_pwrite), .m1_pstb(m1_pstb), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
        .m1_perr(m1_perr),
        .APB_paddr(APB_paddr), .APB_pdata(APB_pdata), .APB_pwrite(APB_pwrite), .APB_pstb(APB_pstb),
        .APB_psel(APB_psel), .APB_penable(APB_penable), .APB_prdata(APB_prdata),
        .APB_pready(APB_pready), .APB_perr(APB_perr), .grant(grant)
    );

    always #5 clk = ~clk;

    // slave: completes after `waits` wait states, logs every completed transfer
    assign APB_pready = APB_penable && (wcnt >= waits);
    assign APB_prdata = slave_rdata;
    assign APB_perr   = slave_err;
    always @(posedge clk) begin
        cyc_no <= cyc_no + 1;
        wcnt   <= (APB_penable && !APB_pready) ? wcnt + 1 : 0;
        if (APB_penable && APB_pready) log_q.push_back('{grant, APB_paddr, APB_pdata, cyc_no});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_paddr = '0; m0_pdata = '0; m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_pstb = '0;
        m1_paddr = '0; m1_pdata = '0; m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_pstb = '0;
    endtask

    task automatic apply_reset();
        idle_masters();
        waits = 0; slave_err = 0; slave_rdata = 32'h0;
        rts = 1; cyc(); rts = 0;
    endtask

    task automatic test_reset();
        idle_masters();
        rts = 1; cyc(); cyc();
        n_cmp++; if (APB_psel !== 1'b0 || APB_penable !== 1'b0) begin n_bad++; $display("FAIL reset_bus_ctl got psel=%b penable=%b want 0 0", APB_psel, APB_penable); end
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant got=%b want=00", grant); end
        n_cmp++; if ({APB_paddr, APB_pdata, APB_pstb, APB_pwrite} !== 69'h0) begin n_bad++; $display("FAIL reset_bus_req got addr=%h data=%h", APB_paddr, APB_pdata); end
        n_cmp++; if ({m0_pready, m0_perr, m1_pready, m1_perr, m0_prdata, m1_prdata} !== 68'h0) begin n_bad++; $display("FAIL reset_masters got m0_prdata=%h m1_prdata=%h", m0_prdata, m1_prdata); end
        rts = 0;
    endtask

    task automatic test_single_read();
        apply_reset();
        slave_rdata = 32'hDEAD_BEEF;
        m0_psel = 1; m0_paddr = 32'h0000_0010; m0_pwrite = 0; m0_pstb = 4'hF;
        n_cmp++; if (APB_psel !== 1'b0) begin n_bad++; $display("FAIL read_c0_idle got psel=%b want 0", APB_psel); end
        cyc(); m0_penable = 1;
        n_cmp++; if ({APB_psel, APB_penable, APB_paddr, grant} !== {1'b1, 1'b0, 32'h10, 2'b01}) begin n_bad++; $display("FAIL read_c1_setup got psel=%b en=%b addr=%h grant=%b want 1 0 00000010 01", APB_psel, APB_penable, APB_paddr, grant); end
        cyc();
        n_cmp++; if ({APB_psel, APB_penable, grant, m0_pready} !== {1'b1, 1'b1, 2'b01, 1'b0}) begin n_bad++; $display("FAIL read_c2_access got psel=%b en=%b grant=%b rdy=%b want 1 1 01 0", APB_psel, APB_penable, grant, m0_pready); end
        cyc();
        n_cmp++; if ({m0_pready, m0_perr, m0_prdata, m1_pready} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin n_bad++; $display("FAIL read_c3_resp got rdy=%b err=%b rdata=%h want 1 0 deadbeef", m0_pready, m0_perr, m0_prdata); end
        n_cmp++; if ({APB_psel, grant} !== {1'b0, 2'b01}) begin n_bad++; $display("FAIL read_c3_bus got psel=%b grant=%b want 0 01", APB_psel, grant); end
        cyc(); m0_psel = 0; m0_penable = 0;
        n_cmp++; if ({grant, m0_pready, m0_prdata} !== {2'b00, 1'b0, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL read_c4_idle got grant=%b rdy=%b rdata=%h want 00 0 deadbeef", grant, m0_pready, m0_prdata); end
    endtask

    task automatic test_back_to_back();
        int n0, n1, c;
        logic adv0, adv1;
        apply_reset();
        log_q.delete();
        n0 = 0; n1 = 0; c = 0; adv0 = 0; adv1 = 0;
        m0_psel = 1; m0_pwrite = 1; m0_pstb = 4'hF; m0_paddr = 32'h100; m0_pdata = 32'hA000_0000;
        m1_psel = 1; m1_pwrite = 1; m1_pstb = 4'hF; m1_paddr = 32'h200; m1_pdata = 32'hB000_0000;
        while ((n0 < 4 || n1 < 4) && c < 100) begin
            cyc(); c++;
            if (adv0) begin adv0 = 0; if (n0 < 4) begin m0_paddr = 32'h100 + 32'(4 * n0); m0_pdata = 32'hA000_0000 + 32'(n0); end else m0_psel = 0; end
            if (adv1) begin adv1 = 0; if (n1 < 4) begin m1_paddr = 32'h200 + 32'(4 * n1); m1_pdata = 32'hB000_0000 + 32'(n1); end else m1_psel = 0; end
            if (m0_pready === 1'b1) begin n0++; adv0 = 1; end
            if (m1_pready === 1'b1) begin n1++; adv1 = 1; end
        end
        n_cmp++; if (c >= 100) begin n_bad++; $display("FAIL b2b_budget got n0=%0d n1=%0d want 4 4", n0, n1); end
        cyc(); m0_psel = 0; m1_psel = 0;
        n_cmp++; if (log_q.size() != 8) begin n_bad++; $display("FAIL b2b_count got=%0d want=8", log_q.size()); end
        for (int k = 0; k < log_q.size(); k++) begin
            logic [1:0]  eg;
            logic [31:0] ed;
            eg = (k % 2 == 1) ? 2'b10 : 2'b01;
            ed = ((k % 2 == 1) ? 32'hB000_0000 : 32'hA000_0000) + 32'(k / 2);
            n_cmp++; if (log_q[k].g !== eg || log_q[k].d !== ed) begin n_bad++; $display("FAIL b2b_xfer%0d got grant=%b data=%h want %b %h", k, log_q[k].g, log_q[k].d, eg, ed); end
            if (k > 0) begin
                n_cmp++; if (log_q[k].t - log_q[k-1].t != 3) begin n_bad++; $display("FAIL b2b_gap%0d got=%0d want=3", k, log_q[k].t - log_q[k-1].t); end
            end
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        waits = 3;
        m1_psel = 1; m1_pwrite = 1; m1_paddr = 32'h300; m1_pdata = 32'h1234_5678; m1_pstb = 4'b0011;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 1) begin m1_penable = 1; m1_paddr = 32'hFFFF_FFFF; m1_pdata = 32'h0; m1_pstb = 4'b1100; m1_pwrite = 0; end
            n_cmp++; if ({APB_psel, APB_paddr, APB_pdata, APB_pstb, APB_pwrite, m1_pready} !== {1'b1, 32'h300, 32'h1234_5678, 4'b0011, 1'b1, 1'b0}) begin n_bad++; $display("FAIL wait_c%0d got psel=%b addr=%h data=%h stb=%b wr=%b rdy=%b", c, APB_psel, APB_paddr, APB_pdata, APB_pstb, APB_pwrite, m1_pready); end
        end
        cyc();
        n_cmp++; if ({m1_pready, m1_perr, APB_psel, m0_pready} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL wait_c6_resp got rdy=%b err=%b psel=%b want 1 0 0", m1_pready, m1_perr, APB_psel); end
        cyc(); m1_psel = 0; m1_penable = 0;
        n_cmp++; if ({grant, m1_pready} !== {2'b00, 1'b0}) begin n_bad++; $display("FAIL wait_c7_idle got grant=%b rdy=%b want 00 0", grant, m1_pready); end
        waits = 0;
    endtask

    task automatic test_error();
        apply_reset();
        slave_err = 1; slave_rdata = 32'h55;
        m0_psel = 1; m0_paddr = 32'h20; m0_pwrite = 0;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            n_cmp++; if ({m1_pready, m1_perr, m0_pready, m0_perr} !== ((c == 3) ? 4'b0011 : 4'b0000)) begin n_bad++; $display("FAIL err_c%0d got m1 %b%b m0 %b%b", c, m1_pready, m1_perr, m0_pready, m0_perr); end
        end
        cyc(); m0_psel = 0;
        n_cmp++; if ({m0_pready, m0_perr} !== 2'b00) begin n_bad++; $display("FAIL err_c4_clear got rdy=%b err=%b want 0 0", m0_pready, m0_perr); end
        slave_err = 0; slave_rdata = 32'h66;
        m1_psel = 1; m1_paddr = 32'h24; m1_pwrite = 0;
        cyc(); cyc(); cyc();
        n_cmp++; if ({m1_pready, m1_perr, m1_prdata} !== {1'b1, 1'b0, 32'h66}) begin n_bad++; $display("FAIL err_m1_clean got rdy=%b err=%b rdata=%h want 1 0 00000066", m1_pready, m1_perr, m1_prdata); end
        cyc(); m1_psel = 0;
    endtask

    task automatic test_reset_mid_transfer();
        apply_reset();
        slave_rdata = 32'hCAFE_0001;
        m1_psel = 1; m1_paddr = 32'h400; m1_pwrite = 0;
        cyc(); cyc(); cyc();
        n_cmp++; if ({m1_pready, m1_prdata} !== {1'b1, 32'hCAFE_0001}) begin n_bad++; $display("FAIL rstmid_pre got rdy=%b rdata=%h want 1 cafe0001", m1_pready, m1_prdata); end
        cyc();
        m1_paddr = 32'h404; m1_pdata = 32'h77; m1_pwrite = 1; m1_pstb = 4'hF;
        cyc(); cyc();
        n_cmp++; if ({APB_penable, APB_pready, grant} !== {1'b1, 1'b1, 2'b10}) begin n_bad++; $display("FAIL rstmid_access got en=%b rdy=%b grant=%b want 1 1 10", APB_penable, APB_pready, grant); end
        rts = 1;
        cyc();
        rts = 0;
        n_cmp++; if ({APB_psel, APB_penable, APB_pwrite, grant} !== 5'b00000) begin n_bad++; $display("FAIL rstmid_ctl got psel=%b en=%b wr=%b grant=%b want 0 0 0 00", APB_psel, APB_penable, APB_pwrite, grant); end
        n_cmp++; if ({APB_paddr, APB_pdata, APB_pstb} !== 68'h0) begin n_bad++; $display("FAIL rstmid_req got addr=%h data=%h stb=%b want 0", APB_paddr, APB_pdata, APB_pstb); end
        n_cmp++; if ({m1_pready, m1_perr, m1_prdata} !== 34'h0) begin n_bad++; $display("FAIL rstmid_resp got rdy=%b err=%b rdata=%h want 0 0 0", m1_pready, m1_perr, m1_prdata); end
        m0_psel = 1; m0_paddr = 32'h500; m0_pwrite = 0;
        cyc();
        n_cmp++; if ({grant, APB_psel, APB_paddr, m1_pready} !== {2'b01, 1'b1, 32'h500, 1'b0}) begin n_bad++; $display("FAIL rstmid_tie got grant=%b psel=%b addr=%h want 01 1 00000500", grant, APB_psel, APB_paddr); end
        idle_masters();
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        waits = 1000; slave_rdata = 32'h99;
        m0_psel = 1; m0_paddr = 32'h600; m0_pwrite = 0;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            n_cmp++; if ({APB_psel, APB_penable, m0_pready} !== {1'b1, (c >= 2), 1'b0}) begin n_bad++; $display("FAIL tmo_c%0d got psel=%b en=%b rdy=%b", c, APB_psel, APB_penable, m0_pready); end
        end
        cyc();
        n_cmp++; if ({m0_pready, m0_perr, m0_prdata, APB_psel, APB_penable} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL tmo_resp got rdy=%b err=%b rdata=%h psel=%b want 1 1 0 0", m0_pready, m0_perr, m0_prdata, APB_psel); end
        cyc(); m0_psel = 0;
        n_cmp++; if ({grant, APB_psel} !== 3'b000) begin n_bad++; $display("FAIL tmo_idle got grant=%b psel=%b want 00 0", grant, APB_psel); end
        waits = 0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid_transfer();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
